mdu_seq: RTL and testbench
==========================

# mdu_seq

Multi-cycle multiply/divide sequencer for the MIPS core. It implements `mult`, `multu`, `div` and `divu` into HI/LO. It has no adder of its own: it drives the core's shared 32-bit ALU, using add (f=010) and subtract (f=110), through dedicated operand/function ports. It sits beside the EX stage; the pipeline stalls on `busy` and captures HI/LO on `done`.

## Interface
- No parameters; width fixed at 32.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request. Sampled only in IDLE.
- `op` in 2: 00 mult, 01 multu, 10 div, 11 divu.
- `a` in 32: rs operand; multiplicand or dividend. Latched on accepted start.
- `b` in 32: rt operand; multiplier or divisor. Latched on accepted start.
- `busy` out 1: high in PREP0..FIX1.
- `done` out 1: one-cycle pulse in DONE.
- `hi` out 32: HI result register.
- `lo` out 32: LO result register.
- `alu_a` out 32: ALU a input.
- `alu_b` out 32: ALU b input.
- `alu_f` out 3: ALU function.
- `alu_y` in 32: ALU result, combinational from `alu_a`, `alu_b` and `alu_f`.

## Operation
- States: IDLE → PREP0 → PREP1 → RUN (32 iterations, 5-bit counter) → FIX0 → FIX1 → DONE → IDLE. No other transitions except reset.
- IDLE with start=1:
  - Latch `op`, `a`, `b`.
  - Set `neg_a`/`neg_b` = sign bits for signed ops, 0 for unsigned.
- Start is ignored outside IDLE. In DONE it is also ignored; the next accepted start is in IDLE, one cycle later.
- PREP0 and PREP1 build the operand magnitudes.
  - PREP0: ALU 0−a (f=110). `ma` ← neg_a ? y : a.
  - PREP1: ALU 0−b (f=110). `mb` ← neg_b ? y : b.
  - Multiply: {hi,lo} ← {0, mb}. Divide: {hi,lo} ← {0, ma}.
- RUN, multiply (f=010):
  - ALU a=hi, b = lo[0] ? ma : 0.
  - Carry c = (a31&b31) | ((a31|b31) & ~y31).
  - {hi,lo} ← {c, y, lo} >> 1, keeping 64 bits.
- RUN, divide (f=110):
  - r = {hi[30:0], lo[31]}, m = hi[31]. ALU a=r, b=mb.
  - Borrow w = (~a31&b31) | (~(a31^b31)&y31). Quotient bit q = m | ~w.
  - hi ← q ? y : r.
  - lo ← {lo[30:0], q}.
- FIX0 and FIX1 apply sign correction.
  - Signed multiply, neg_a^neg_b=1:
    - FIX0: lo ← 0−lo.
    - FIX1: hi ← ~hi + (lo_pre==0) via f=010. `lo_pre` is the pre-FIX0 value, held in a 1-bit flag.
  - Signed divide:
    - FIX0: lo ← 0−lo if neg_a^neg_b.
    - FIX1: hi ← 0−hi if neg_a.
  - Otherwise hi/lo hold unchanged.
- Divide by zero (b==0, signed or unsigned): fix-up is suppressed. Result is lo=FFFFFFFF, hi=|a| for div or a for divu, i.e. the raw restoring result.
- Overflow case 80000000÷FFFFFFFF: lo=80000000, hi=0. No trap.
- In IDLE and DONE: alu_a=alu_b=0, alu_f=010.
- hi/lo hold their value from DONE until the next PREP0 overwrite.

## Timing
- Start sampled at edge N: PREP0 in the cycle after N; DONE in the cycle after edge N+36.
- Latency is 37 cycles for every op and operand, divide-by-zero included.
- busy=1 for exactly 36 cycles. done=1 for exactly 1 cycle, with valid hi/lo.
- Reset, at any time including mid-operation: state=IDLE, hi=lo=0, busy=done=0, alu_a=alu_b=0, alu_f=010. The in-flight result is discarded.
- All outputs are registered, except alu_a/alu_b/alu_f, which are decoded combinationally from state and registers.

## Configuration
- `MDU_DIV_EN` defined: divide is supported as above.
- `MDU_DIV_EN` undefined:
  - Divide datapath and FIX divide logic are removed.
  - op 10/11 still takes the full 37-cycle state walk, but leaves the ALU idle (a=b=0, f=010).
  - DONE presents hi=lo=0.
  - Multiply is unchanged.

## Test plan
- multu FFFFFFFF×FFFFFFFF → done at N+37, hi=FFFFFFFE, lo=00000001; busy high 36 cycles.
- mult FFFFFFFD×00000007 → hi=FFFFFFFF, lo=FFFFFFEB. mult 80000000×80000000 → hi=40000000, lo=0.
- div FFFFFFF9÷00000002 → lo=FFFFFFFD, hi=FFFFFFFF. div 80000000÷FFFFFFFF → lo=80000000, hi=0.
- divu 00000064÷0 → lo=FFFFFFFF, hi=00000064. With `MDU_DIV_EN` undefined, same stimulus → hi=lo=0 at N+37.
- Start re-pulsed at N+10 with different operands → ignored; the original result appears at N+37.
- Reset asserted asynchronously at N+20 → busy, done, hi and lo go to 0 immediately. A new multu 3×5 started afterwards → lo=0000000F, hi=0.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: sequencer for mult/multu/div/divu that drives the core's shared 32-bit ALU into HI/LO.
// Define MDU_DIV_EN to build the divide datapath; otherwise div/divu walk the states and return zero.
module mdu_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_f,
   input  logic [31:0] alu_y
);

   localparam logic [2:0] F_ADD = 3'b010;
   localparam logic [2:0] F_SUB = 3'b110;

   // Handshake: start is a request sampled only in S_IDLE; busy covers PREP0..FIX1 and
   // done is a single-cycle pulse in S_DONE while hi/lo already hold the final result.
   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP0,
      S_PREP1,
      S_RUN,
      S_FIX0,
      S_FIX1,
      S_DONE
   } state_t;

   state_t      state_q;
   logic        div_q;
   logic        neg_a_q, neg_b_q;
   logic [31:0] a_q, b_q;
   logic [31:0] ma_q, ma_d;
   logic [31:0] mb_q, mb_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        lo_zero_q, lo_zero_d;
   logic [4:0]  cnt_q;
   logic        busy_q, done_q;

   logic        mul_act, div_act, op_act;
   logic        mul_fix, div_fix_lo, div_fix_hi;
   logic        carry;

   assign mul_act = ~div_q;
   assign op_act  = mul_act | div_act;
   assign mul_fix = mul_act & (neg_a_q ^ neg_b_q);
   assign carry   = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_y[31]);

`ifdef MDU_DIV_EN
   logic [31:0] rem;
   logic        borrow, q_bit, b_zero;

   assign div_act    = div_q;
   // A zero divisor leaves the raw restoring result, so sign fix-up is skipped.
   assign b_zero     = (b_q == 32'd0);
   assign div_fix_lo = div_act & ~b_zero & (neg_a_q ^ neg_b_q);
   assign div_fix_hi = div_act & ~b_zero & neg_a_q;
   assign rem        = {hi_q[30:0], lo_q[31]};
   assign borrow     = (~alu_a[31] & alu_b[31]) | (~(alu_a[31] ^ alu_b[31]) & alu_y[31]);
   assign q_bit      = hi_q[31] | ~borrow;
`else
   assign div_act    = 1'b0;
   assign div_fix_lo = 1'b0;
   assign div_fix_hi = 1'b0;
`endif

   always_comb begin
      alu_a = 32'd0;
      alu_b = 32'd0;
      alu_f = F_ADD;
      case (state_q)
         S_PREP0: begin
            if (op_act) begin
               alu_f = F_SUB;
               alu_b = a_q;
            end
         end
         S_PREP1: begin
            if (op_act) begin
               alu_f = F_SUB;
               alu_b = b_q;
            end
         end
         S_RUN: begin
            if (mul_act) begin
               alu_a = hi_q;
               alu_b = lo_q[0] ? ma_q : 32'd0;
            end
`ifdef MDU_DIV_EN
            else if (div_act) begin
               alu_f = F_SUB;
               alu_a = rem;
               alu_b = mb_q;
            end
`endif
         end
         S_FIX0: begin
            if (mul_fix || div_fix_lo) begin
               alu_f = F_SUB;
               alu_b = lo_q;
            end
         end
         S_FIX1: begin
            // Upper word of a 64-bit negate: invert and carry in when the low word was zero.
            if (mul_fix) begin
               alu_a = ~hi_q;
               alu_b = {31'd0, lo_zero_q};
            end else if (div_fix_hi) begin
               alu_f = F_SUB;
               alu_b = hi_q;
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      ma_d      = ma_q;
      mb_d      = mb_q;
      lo_zero_d = lo_zero_q;
      case (state_q)
         S_PREP0: begin
            hi_d = 32'd0;
            lo_d = 32'd0;
            if (op_act) ma_d = neg_a_q ? alu_y : a_q;
         end
         S_PREP1: begin
            if (op_act) begin
               mb_d = neg_b_q ? alu_y : b_q;
               lo_d = mul_act ? mb_d : ma_q;
            end
         end
         S_RUN: begin
            if (mul_act) begin
               hi_d = {carry, alu_y[31:1]};
               lo_d = {alu_y[0], lo_q[31:1]};
            end
`ifdef MDU_DIV_EN
            else if (div_act) begin
               hi_d = q_bit ? alu_y : rem;
               lo_d = {lo_q[30:0], q_bit};
            end
`endif
         end
         S_FIX0: begin
            lo_zero_d = (lo_q == 32'd0);
            if (mul_fix || div_fix_lo) lo_d = alu_y;
         end
         S_FIX1: begin
            if (mul_fix || div_fix_hi) hi_d = alu_y;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         div_q     <= 1'b0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         ma_q      <= 32'd0;
         mb_q      <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         lo_zero_q <= 1'b0;
         cnt_q     <= 5'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         ma_q      <= ma_d;
         mb_q      <= mb_d;
         lo_zero_q <= lo_zero_d;
         done_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  div_q   <= op[1];
                  a_q     <= a;
                  b_q     <= b;
                  neg_a_q <= ~op[0] & a[31];
                  neg_b_q <= ~op[0] & b[31];
                  busy_q  <= 1'b1;
                  state_q <= S_PREP0;
               end
            end
            S_PREP0: state_q <= S_PREP1;
            S_PREP1: begin
               cnt_q   <= 5'd0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= S_FIX0;
            end
            S_FIX0: state_q <= S_FIX1;
            S_FIX1: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

   a_busy_done_excl: assert property (@(posedge clk) disable iff (reset) !(busy_q && done_q));
   a_done_one_cycle: assert property (@(posedge clk) disable iff (reset) done_q |=> !done_q);

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: table vectors, randomized ops against an arithmetic reference model, and
// hand sequences for re-pulsed start, start in DONE and asynchronous reset mid-operation.
module tb_mdu_seq;

`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;
   logic [31:0] alu_a, alu_b, alu_y;
   logic [2:0]  alu_f;

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          pulse;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t tbl[$];

   mdu_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo),
      .alu_a (alu_a),
      .alu_b (alu_b),
      .alu_f (alu_f),
      .alu_y (alu_y)
   );

   // Shared core ALU seen by the sequencer.
   always_comb begin
      case (alu_f)
         3'b010:  alu_y = alu_a + alu_b;
         3'b110:  alu_y = alu_a - alu_b;
         default: alu_y = 32'd0;
      endcase
   end

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input int p, input logic [31:0] eh, input logic [31:0] el);
      vec_t v;
      v.op = o; v.a = x; v.b = y; v.pulse = p; v.hi = eh; v.lo = el;
      return v;
   endfunction

   // Reference model: {hi, lo} from plain 64-bit arithmetic and the MIPS divide rules.
   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
      longint      sx, sy;
      int          qi, ri;
      logic [31:0] ax;
      sx = 0; sy = 0; qi = 0; ri = 0;
      ax = x[31] ? (32'd0 - x) : x;
      case (o)
         2'b00: begin
            sx = $signed(x);
            sy = $signed(y);
            return 64'(sx * sy);
         end
         2'b01: return {32'd0, x} * {32'd0, y};
         2'b11: begin
            if (!DIV_EN) return 64'd0;
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
         default: begin
            if (!DIV_EN) return 64'd0;
            if (y == 32'd0) return {ax, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            qi = $signed(x) / $signed(y);
            ri = $signed(x) % $signed(y);
            return {32'(ri), 32'(qi)};
         end
      endcase
   endfunction

   // Driver: issue one op, optionally re-pulse start at observation k, collect the result.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int pulse_k, output logic [63:0] res, output int lat,
                         output int bcnt, output bit alu_idle, output bit got);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = ~o; a = $urandom; b = $urandom;
      res = 64'd0; lat = 0; bcnt = 0; alu_idle = 1'b1; got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (busy && (alu_a != 32'd0 || alu_b != 32'd0 || alu_f != 3'b010)) alu_idle = 1'b0;
         if (done) begin
            got = 1'b1;
            lat = k + 1;
            res = {hi, lo};
         end
         start = (k == pulse_k);
         if (start) begin
            op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
         end
      end
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int pulse_k);
      logic [63:0] res, exp;
      int          lat, bcnt;
      bit          alu_idle, got;
      run_op(o, x, y, pulse_k, res, lat, bcnt, alu_idle, got);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      check({tag, "_done_seen"}, 64'(got), 64'd1);
      check({tag, "_result"}, res, exp);
      check({tag, "_latency"}, 64'(lat), 64'd37);
      check({tag, "_busy_cycles"}, 64'(bcnt), 64'd36);
      check({tag, "_done_width"}, 64'(done), 64'd0);
      check({tag, "_idle_after"}, 64'(busy), 64'd0);
      check({tag, "_hold"}, {hi, lo}, exp);
      if (o[1] && !DIV_EN) check({tag, "_alu_idle"}, 64'(alu_idle), 64'd1);
   endtask

   initial begin
      logic [1:0]  o;
      logic [31:0] x, y;
      int          p;
      bit          seen;

      reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_alu", {alu_a, alu_b, 29'd0, alu_f}, {64'd0, 29'd0, 3'b010});
      reset = 1'b0;
      @(negedge clk);

      tbl.push_back(mk(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 32'hFFFF_FFFE, 32'h0000_0001));
      tbl.push_back(mk(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, -1, 32'hFFFF_FFFF, 32'hFFFF_FFEB));
      tbl.push_back(mk(2'b00, 32'h8000_0000, 32'h8000_0000, -1, 32'h4000_0000, 32'h0000_0000));
      tbl.push_back(mk(2'b00, 32'hFFFF_FFFF, 32'h0000_0000, -1, 32'h0000_0000, 32'h0000_0000));
      tbl.push_back(mk(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
      tbl.push_back(mk(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
      tbl.push_back(mk(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h0000_0000, 32'h8000_0000));
      tbl.push_back(mk(2'b11, 32'h0000_0064, 32'h0000_0000, -1, 32'h0000_0064, 32'hFFFF_FFFF));
      tbl.push_back(mk(2'b10, 32'hFFFF_FF9C, 32'h0000_0000, -1, 32'h0000_0064, 32'hFFFF_FFFF));
      tbl.push_back(mk(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, -1, 32'h0000_0001, 32'hFFFF_FFFD));
      tbl.push_back(mk(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, -1, 32'h7FFF_FFFE, 32'h0000_0001));
      tbl.push_back(mk(2'b01, 32'h0000_0003, 32'h0000_0005,  9, 32'h0000_0000, 32'h0000_000F));
      tbl.push_back(mk(2'b00, 32'h1234_5678, 32'hFFFF_0000, 36, 32'hFFFF_EDCB, 32'hA988_0000));

      for (int i = 0; i < tbl.size(); i++) begin
         exp_q.push_back((tbl[i].op[1] && !DIV_EN) ? 64'd0 : {tbl[i].hi, tbl[i].lo});
         do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].pulse);
      end

      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: y = 32'($urandom_range(1, 15));
            3: x = 32'($urandom_range(0, 1000));
            4: y = {1'b1, 31'($urandom_range(0, 3))};
            default: begin end
         endcase
         p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 36)) : -1;
         exp_q.push_back(ref_model(o, x, y));
         do_op($sformatf("rnd%0d", i), o, x, y, p);
      end

      // Asynchronous reset in the middle of an operation discards it.
      @(negedge clk);
      op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_pre_busy", 64'(busy), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      check("rst_alu", {alu_a, alu_b, 29'd0, alu_f}, {64'd0, 29'd0, 3'b010});
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (45) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      check("rst_discard", 64'(seen), 64'd0);
      exp_q.push_back(ref_model(2'b01, 32'd3, 32'd5));
      do_op("post_rst", 2'b01, 32'd3, 32'd5, -1);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
